// File: rtl/msaga_tsi_adapter.sv
// msaga_tsi_adapter
//   Bridges a 32-bit TSI word stream to a simple single-outstanding memory
//   request/response port. Host packets are CMD, ADDR_LO, ADDR_HI, LEN_LO,
//   LEN_HI followed (for writes) by LEN+1 data words; reads return LEN+1
//   words on tsi_out. Addresses advance by 4 bytes per word, modulo 2^64.
//
//   Build option: define MSAGA_TSI_BADCMD_EN to add the sticky bad_cmd flag.
//   With it, a CMD word above 1 flags bad_cmd and the four header words that
//   follow are swallowed without issuing any memory traffic. Without it only
//   bit 0 of CMD is decoded (odd = write) and the bad_cmd port is absent.
//
//   Every output comes straight from a flop: handshake strobes are computed
//   from the next state so they line up with the state register.

module msaga_tsi_adapter (
    input  logic        clock,
    input  logic        reset,
    input  logic        tsi_in_valid,
    output logic        tsi_in_ready,
    input  logic [31:0] tsi_in_bits,
    output logic        tsi_out_valid,
    input  logic        tsi_out_ready,
    output logic [31:0] tsi_out_bits,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [63:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_resp_data
`ifdef MSAGA_TSI_BADCMD_EN
    ,
    output logic        bad_cmd
`endif
);

    // FSM encoding
    localparam logic [3:0] S_CMD     = 4'd0;
    localparam logic [3:0] S_ADDR_LO = 4'd1;
    localparam logic [3:0] S_ADDR_HI = 4'd2;
    localparam logic [3:0] S_LEN_LO  = 4'd3;
    localparam logic [3:0] S_LEN_HI  = 4'd4;
    localparam logic [3:0] S_WR_DATA = 4'd5;
    localparam logic [3:0] S_WR_REQ  = 4'd6;
    localparam logic [3:0] S_RD_REQ  = 4'd7;
    localparam logic [3:0] S_RD_RESP = 4'd8;
    localparam logic [3:0] S_RD_SEND = 4'd9;

    // Packet / datapath state
    logic [3:0]  state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [63:0] addr_q,  addr_d;
    logic [63:0] rem_q,   rem_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    // Registered handshake strobes
    logic        in_rdy_q,   in_rdy_d;
    logic        out_vld_q,  out_vld_d;
    logic        req_vld_q,  req_vld_d;
    logic        req_wr_q,   req_wr_d;
    logic        resp_rdy_q, resp_rdy_d;

`ifdef MSAGA_TSI_BADCMD_EN
    // is_bad marks the packet being swallowed; bad_q is the sticky flag
    logic        is_bad_q, is_bad_d;
    logic        bad_q,    bad_d;
`endif

    logic in_fire, out_fire, req_fire, resp_fire;

    assign in_fire   = tsi_in_valid   & in_rdy_q;
    assign out_fire  = out_vld_q      & tsi_out_ready;
    assign req_fire  = req_vld_q      & mem_req_ready;
    assign resp_fire = mem_resp_valid & resp_rdy_q;

    assign tsi_in_ready   = in_rdy_q;
    assign tsi_out_valid  = out_vld_q;
    assign tsi_out_bits   = rdata_q;
    assign mem_req_valid  = req_vld_q;
    assign mem_req_write  = req_wr_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_data   = wdata_q;
    assign mem_resp_ready = resp_rdy_q;
`ifdef MSAGA_TSI_BADCMD_EN
    assign bad_cmd        = bad_q;
`endif

    // Next-state: packet parsing, transfer sequencing and strobe decode
    always_comb begin
        state_d  = state_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef MSAGA_TSI_BADCMD_EN
        is_bad_d = is_bad_q;
        bad_d    = bad_q;
`endif

        case (state_q)
            S_CMD: begin
                if (in_fire) begin
                    is_wr_d = tsi_in_bits[0];
`ifdef MSAGA_TSI_BADCMD_EN
                    is_bad_d = (tsi_in_bits > 32'd1);
                    if (tsi_in_bits > 32'd1) begin
                        bad_d = 1'b1;
                    end
`endif
                    state_d = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (in_fire) begin
                    addr_d[31:0] = tsi_in_bits;
                    state_d      = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                if (in_fire) begin
                    addr_d[63:32] = tsi_in_bits;
                    state_d       = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (in_fire) begin
                    rem_d[31:0] = tsi_in_bits;
                    state_d     = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (in_fire) begin
                    rem_d[63:32] = tsi_in_bits;
`ifdef MSAGA_TSI_BADCMD_EN
                    if (is_bad_q) begin
                        // header of an illegal packet fully swallowed
                        state_d = S_CMD;
                    end else
`endif
                    if (is_wr_q) begin
                        state_d = S_WR_DATA;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_WR_DATA: begin
                if (in_fire) begin
                    wdata_d = tsi_in_bits;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (req_fire) begin
                    if (rem_q == 64'd0) begin
                        state_d = S_CMD;
                    end else begin
                        addr_d  = addr_q + 64'd4;
                        rem_d   = rem_q - 64'd1;
                        state_d = S_WR_DATA;
                    end
                end
            end
            S_RD_REQ: begin
                if (req_fire) begin
                    state_d = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (resp_fire) begin
                    rdata_d = mem_resp_data;
                    state_d = S_RD_SEND;
                end
            end
            S_RD_SEND: begin
                if (out_fire) begin
                    if (rem_q == 64'd0) begin
                        state_d = S_CMD;
                    end else begin
                        addr_d  = addr_q + 64'd4;
                        rem_d   = rem_q - 64'd1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            default: begin
                state_d = S_CMD;
            end
        endcase

        // strobes follow the state being entered so they are flop outputs
        in_rdy_d   = (state_d == S_CMD)     || (state_d == S_ADDR_LO) ||
                     (state_d == S_ADDR_HI) || (state_d == S_LEN_LO)  ||
                     (state_d == S_LEN_HI)  || (state_d == S_WR_DATA);
        req_vld_d  = (state_d == S_WR_REQ) || (state_d == S_RD_REQ);
        req_wr_d   = (state_d == S_WR_REQ);
        resp_rdy_d = (state_d == S_RD_RESP);
        out_vld_d  = (state_d == S_RD_SEND);
    end

    // State and strobe registers; reset drops every handshake strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_CMD;
            is_wr_q    <= 1'b0;
            addr_q     <= 64'd0;
            rem_q      <= 64'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            in_rdy_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            req_vld_q  <= 1'b0;
            req_wr_q   <= 1'b0;
            resp_rdy_q <= 1'b0;
`ifdef MSAGA_TSI_BADCMD_EN
            is_bad_q   <= 1'b0;
            bad_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            in_rdy_q   <= in_rdy_d;
            out_vld_q  <= out_vld_d;
            req_vld_q  <= req_vld_d;
            req_wr_q   <= req_wr_d;
            resp_rdy_q <= resp_rdy_d;
`ifdef MSAGA_TSI_BADCMD_EN
            is_bad_q   <= is_bad_d;
            bad_q      <= bad_d;
`endif
        end
    end

endmodule

// File: tb/tb_msaga_tsi_adapter.sv
// tb_msaga_tsi_adapter
//   Host-side stimulus runs in one initial block; a randomly stalling memory
//   model answers requests. Expected request streams and read data come from
//   a packet-level model: address i of a packet is base + 4*i (64-bit wrap),
//   write data goes into a reference memory, reads return reference contents.
//   Inputs change 1 time unit after the rising edge; monitors sample on the
//   falling edge.

module tb_msaga_tsi_adapter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tsi_in_valid = 1'b0;
    logic        tsi_in_ready;
    logic [31:0] tsi_in_bits = 32'd0;
    logic        tsi_out_valid;
    logic        tsi_out_ready = 1'b0;
    logic [31:0] tsi_out_bits;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_write;
    logic [63:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_resp_valid = 1'b0;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_data = 32'd0;
`ifdef MSAGA_TSI_BADCMD_EN
    logic        bad_cmd;
`endif

    always #5 clock = ~clock;

    msaga_tsi_adapter dut (
        .clock          (clock),
        .reset          (reset),
        .tsi_in_valid   (tsi_in_valid),
        .tsi_in_ready   (tsi_in_ready),
        .tsi_in_bits    (tsi_in_bits),
        .tsi_out_valid  (tsi_out_valid),
        .tsi_out_ready  (tsi_out_ready),
        .tsi_out_bits   (tsi_out_bits),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data)
`ifdef MSAGA_TSI_BADCMD_EN
        ,
        .bad_cmd        (bad_cmd)
`endif
    );

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        req_log[$];               // requests seen on the memory port
    logic [31:0] resp_q[$];                // read data owed by the memory
    logic [31:0] dut_mem[logic [63:0]];    // memory as written through the DUT
    logic [31:0] ref_mem[logic [63:0]];    // memory implied by packets sent
    logic [31:0] fixed_data[$];            // directed write data, else random
    int          checks = 0;
    int          errors = 0;
    int          stall_next = 0;

    // power-on memory content, shared by both memory views
    function automatic logic [31:0] init_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // memory side: random request acceptance, random response timing,
    // and junk response pulses while nothing is owed
    always begin
        tick();
        if (reset) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
        end else begin
            if (mem_req_valid && stall_next > 0) begin
                mem_req_ready = 1'b0;
                stall_next--;
            end else begin
                mem_req_ready = ($urandom_range(0, 3) != 0);
            end
            if (resp_q.size() > 0) begin
                mem_resp_valid = ($urandom_range(0, 2) != 0);
                mem_resp_data  = resp_q[0];
            end else begin
                mem_resp_valid = ($urandom_range(0, 3) == 0);
                mem_resp_data  = $urandom;
            end
        end
    end

    // monitor: hold-stability under backpressure, request logging
    bit          hold_req = 0;
    bit          hold_out = 0;
    req_t        held_req;
    logic [31:0] held_out;
    always @(negedge clock) begin
        if (reset) begin
            hold_req = 0;
            hold_out = 0;
        end else begin
            if (hold_req) begin
                check("req_hold_valid", 64'(mem_req_valid), 64'd1);
                check("req_hold_write", 64'(mem_req_write), 64'(held_req.wr));
                check("req_hold_addr", mem_req_addr, held_req.addr);
                if (held_req.wr) check("req_hold_data", 64'(mem_req_data), 64'(held_req.data));
            end
            if (hold_out) begin
                check("out_hold_valid", 64'(tsi_out_valid), 64'd1);
                check("out_hold_bits", 64'(tsi_out_bits), 64'(held_out));
            end
            hold_req = mem_req_valid && !mem_req_ready;
            held_req = '{mem_req_write, mem_req_addr, mem_req_data};
            hold_out = tsi_out_valid && !tsi_out_ready;
            held_out = tsi_out_bits;
            if (mem_req_valid && mem_req_ready) begin
                req_log.push_back('{mem_req_write, mem_req_addr, mem_req_data});
                if (mem_req_write) dut_mem[mem_req_addr] = mem_req_data;
                else resp_q.push_back(dut_mem.exists(mem_req_addr) ?
                                      dut_mem[mem_req_addr] : init_word(mem_req_addr));
            end
            if (mem_resp_valid && mem_resp_ready) begin
                check("resp_outstanding", 64'(resp_q.size() > 0), 64'd1);
                if (resp_q.size() > 0) void'(resp_q.pop_front());
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        repeat ($urandom_range(0, 1)) tick();
        tsi_in_valid = 1'b1;
        tsi_in_bits  = w;
        while (!tsi_in_ready && n < 300) begin tick(); n++; end
        if (!tsi_in_ready) check("send_timeout", 64'(tsi_in_ready), 64'd1);
        tick();
        tsi_in_valid = 1'b0;
        tsi_in_bits  = $urandom;
    endtask

    task automatic recv_word(output logic [31:0] w, input int stall);
        int n = 0;
        tsi_out_ready = 1'b0;
        while (!tsi_out_valid && n < 300) begin tick(); n++; end
        if (!tsi_out_valid) check("recv_timeout", 64'(tsi_out_valid), 64'd1);
        repeat (stall) tick();
        w = tsi_out_bits;
        tsi_out_ready = 1'b1;
        tick();
        tsi_out_ready = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] cmd, input logic [63:0] addr, input int len);
        send_word(cmd);
        send_word(addr[31:0]);
        send_word(addr[63:32]);
        send_word(32'(len));
        send_word(32'd0);
    endtask

    task automatic wait_reqs(input int n);
        int k = 0;
        while (req_log.size() < n && k < 500) begin tick(); k++; end
        check("req_count", 64'(req_log.size()), 64'(n));
    endtask

    task automatic wait_cmd_ready();
        int k = 0;
        while (!tsi_in_ready && k < 300) begin tick(); k++; end
        check("back_in_cmd", 64'(tsi_in_ready), 64'd1);
    endtask

    // one full packet, checked against the packet-level model
    task automatic run_packet(input logic [31:0] cmd, input logic [63:0] addr,
                              input int len, input int out_stall);
        req_t        exp_q[$];
        logic [31:0] exp_out[$];
        logic [31:0] d;
        logic [63:0] a;
        req_t        r;
        send_header(cmd, addr, len);
        for (int i = 0; i <= len; i++) begin
            a = addr + 64'(4 * i);
            if (cmd[0]) begin
                d = (fixed_data.size() > 0) ? fixed_data.pop_front() : $urandom;
                send_word(d);
                exp_q.push_back('{1'b1, a, d});
                ref_mem[a] = d;
            end else begin
                exp_q.push_back('{1'b0, a, 32'd0});
                exp_out.push_back(ref_mem.exists(a) ? ref_mem[a] : init_word(a));
            end
        end
        if (!cmd[0]) begin
            for (int i = 0; i <= len; i++) begin
                recv_word(d, (out_stall < 0) ? $urandom_range(0, 2) : out_stall);
                check("rd_data", 64'(d), 64'(exp_out[i]));
            end
        end
        wait_reqs(len + 1);
        for (int i = 0; i <= len && req_log.size() > 0; i++) begin
            r = req_log.pop_front();
            check("req_write", 64'(r.wr), 64'(exp_q[i].wr));
            check("req_addr", r.addr, exp_q[i].addr);
            if (exp_q[i].wr) check("req_data", 64'(r.data), 64'(exp_q[i].data));
        end
        wait_cmd_ready();
        repeat (3) tick();
        check("no_extra_req", 64'(req_log.size()), 64'd0);
        req_log.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(tsi_in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(tsi_out_valid), 64'd0);
        check({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
        check({tag, "_resp_ready"}, 64'(mem_resp_ready), 64'd0);
`ifdef MSAGA_TSI_BADCMD_EN
        check({tag, "_bad_cmd"}, 64'(bad_cmd), 64'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [31:0] d0;
        req_t        r;
        int          k;

        // reset state
        repeat (2) tick();
        check_idle_outputs("rst");
        check("rst_addr", mem_req_addr, 64'd0);
        check("rst_out_bits", 64'(tsi_out_bits), 64'd0);
        check("rst_req_data", 64'(mem_req_data), 64'd0);
        reset = 1'b0;
        tick();
        check("cmd_ready_after_rst", 64'(tsi_in_ready), 64'd1);

        // basic two-word write
        fixed_data.push_back(32'hAAAA0001);
        fixed_data.push_back(32'hAAAA0002);
        run_packet(32'd1, 64'h1000, 1, 0);

        // three-word read of preloaded data
        for (int i = 0; i < 3; i++) begin
            a = 64'h2000 + 64'(4 * i);
            d0 = 32'h11 * 32'(i + 1);
            ref_mem[a] = d0;
            dut_mem[a] = d0;
        end
        run_packet(32'd0, 64'h2000, 2, 0);

        // backpressure: memory stalls 5 cycles, host holds off 3 cycles
        stall_next = 5;
        run_packet(32'd1, 64'h4000, 2, 0);
        stall_next = 5;
        run_packet(32'd0, 64'h4000, 2, 3);

        // address wrap at the top of the 64-bit space
        run_packet(32'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0);
        run_packet(32'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1, -1);

        // LEN=0 moves exactly one word
        run_packet(32'd1, 64'h6000, 0, 0);
        run_packet(32'd0, 64'h6000, 0, 0);

        // reset while waiting for write data of a LEN=3 write
        send_header(32'd1, 64'h5000, 3);
        d0 = $urandom;
        send_word(d0);
        wait_reqs(1);
        k = 0;
        while (!tsi_in_ready && k < 300) begin tick(); k++; end
        reset = 1'b1;
        tick();
        check_idle_outputs("midrst");
        tick();
        resp_q.delete();
        reset = 1'b0;
        repeat (20) tick();
        check("midrst_reqs", 64'(req_log.size()), 64'd1);
        if (req_log.size() > 0) begin
            r = req_log.pop_front();
            check("midrst_req_addr", r.addr, 64'h5000);
            check("midrst_req_data", 64'(r.data), 64'(d0));
        end
        ref_mem[64'h5000] = d0;
        req_log.delete();
        run_packet(32'd0, 64'h2000, 2, -1);

`ifdef MSAGA_TSI_BADCMD_EN
        // illegal command: header swallowed, flag sticks, next read is fine
        send_word(32'd7);
        for (int i = 0; i < 4; i++) send_word($urandom);
        wait_cmd_ready();
        repeat (5) tick();
        check("bad_cmd_set", 64'(bad_cmd), 64'd1);
        check("bad_no_req", 64'(req_log.size()), 64'd0);
        run_packet(32'd0, 64'h2000, 2, -1);
        check("bad_cmd_sticky", 64'(bad_cmd), 64'd1);
`else
        // only bit 0 of CMD is decoded
        run_packet(32'd3, 64'h7000, 1, 0);
        run_packet(32'd2, 64'h7000, 1, -1);
`endif

        // randomized packets over a small address pool plus wrap region
        for (int p = 0; p < 24; p++) begin
            if ($urandom_range(0, 3) == 0)
                a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
            else
                a = 64'h3000 + 64'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) stall_next = $urandom_range(1, 6);
            run_packet(32'($urandom_range(0, 1)), a, $urandom_range(0, 4), -1);
        end

        // final reset clears everything again
        reset = 1'b1;
        tick();
        check_idle_outputs("final_rst");
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
